pong_game_ctrl: RTL and testbench
=================================

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 SHALL have parameter SCREEN_W, default 640, visible width in pixels.
REQ-002 SHALL have parameter SCREEN_H, default 480, visible height in pixels.
REQ-003 SHALL have parameter PADDLE_W, default 20, and PADDLE_H, default 80, paddle size in pixels.
REQ-004 SHALL have parameter BALL_SIZE, default 8, square ball edge in pixels.
REQ-005 SHALL have parameters BALL_SPEED, default 2, and PADDLE_SPEED, default 4, pixels moved per frame.
REQ-006 SHALL have parameter WIN_SCORE, default 7, points that end a game.
REQ-007 SHALL have parameter POINT_FRAMES, default 60, pause length after a point.
REQ-008 SHALL have ports: pixel_clk in 1, sole clock; reset in 1, asynchronous, active-high.
REQ-009 SHALL have ports: V_visible in 1, display driver vertical-visible flag; serve in 1, level.
REQ-010 SHALL have ports: p1_up, p1_down, p2_up, p2_down in 1 each, level paddle commands.
REQ-011 SHALL have ports: p1_paddle_Y, p2_paddle_Y, ball_X, ball_Y out 10 each, top-left coordinates.
REQ-012 SHALL have ports: p1_score, p2_score out 4 each; game_state out 2; winner out 2 (0 none, 1 P1, 2 P2).

Function
REQ-013 SHALL generate frame_tick for one cycle on the registered falling edge of V_visible; all position, score and state updates SHALL occur only on frame_tick, with outputs valid the following cycle.
REQ-014 SHALL implement states SERVE=0, PLAY=1, POINT=2, GAME_OVER=3, reported on game_state.
REQ-015 In SERVE: ball SHALL sit at ((SCREEN_W-BALL_SIZE)/2, (SCREEN_H-BALL_SIZE)/2) = (316,236); on a tick with serve=1, state SHALL become PLAY with dx toward the serve target and dy=down.
REQ-016 Serve target SHALL be P2 (rightward) after reset/game restart, otherwise the player who conceded the last point.
REQ-017 In PLAY each tick, ball SHALL move BALL_SPEED in X and Y per dx/dy.
REQ-018 Wall: moving up with ball_Y <= BALL_SPEED SHALL set ball_Y=0 and dy=down; moving down with ball_Y >= SCREEN_H-BALL_SIZE-BALL_SPEED SHALL set ball_Y=SCREEN_H-BALL_SIZE and dy=up.
REQ-019 Left edge: moving left with ball_X <= PADDLE_W+BALL_SPEED and ball_Y in [p1_paddle_Y-BALL_SIZE+1, p1_paddle_Y+PADDLE_H-1] SHALL set ball_X=PADDLE_W, dx=right; without overlap, once ball_X < BALL_SPEED, p2_score SHALL increment and state SHALL become POINT.
REQ-020 Right edge SHALL mirror REQ-019 with paddle at X=SCREEN_W-PADDLE_W, ball_X set to SCREEN_W-PADDLE_W-BALL_SIZE, scoring for P1.
REQ-021 Simultaneous wall and paddle hit in one tick SHALL flip both dx and dy.
REQ-022 Paddles SHALL move PADDLE_SPEED per tick in every state except GAME_OVER, clamped to [0, SCREEN_H-PADDLE_H]=[0,400]; up and down both asserted SHALL hold position.
REQ-023 POINT SHALL hold the ball at center for POINT_FRAMES ticks, then go to GAME_OVER if either score equals WIN_SCORE (winner set), else SERVE.
REQ-024 GAME_OVER SHALL freeze all positions; a tick with serve=1 SHALL clear scores and winner and enter SERVE.
REQ-025 Scores SHALL saturate at WIN_SCORE.

Reset
REQ-026 Reset SHALL asynchronously force SERVE, ball at center, both paddles at (SCREEN_H-PADDLE_H)/2=200, scores 0, winner 0, frame counter 0, edge-detect register 0, serve target P2.
REQ-027 Reset asserted mid-PLAY or mid-POINT SHALL abandon the rally with no score change beyond those values.

Configuration
REQ-028 With PONG_AI_EN defined, p2 paddle SHALL ignore p2_up/p2_down and move PADDLE_SPEED per tick toward the position centring it on ball_Y, holding when within PADDLE_SPEED; without it, p2 SHALL follow its buttons per REQ-022.

Structure
REQ-029 Package pong_pkg SHALL hold the game-state enum, the winner encoding and the default screen/paddle/ball constants.
REQ-030 Paddle motion and clamping SHALL be one sub-module, paddle_mover, instanced once per player.

Verification
REQ-031 Reset, 3 frames, serve=1 on frame 4 -> state PLAY, ball at (318,238) one frame later.
REQ-032 p1_up held from paddle Y=200 for 60 frames -> Y=0 after 50 frames, stays 0; p1_up and p1_down together -> Y unchanged.
REQ-033 Ball moving left at (22,100), p1_paddle_Y=60 -> ball_X=20, dx=right next frame, no score.
REQ-034 Ball moving left at (1,300), p1_paddle_Y=0 -> p2_score=1, state POINT, SERVE after 60 frames with leftward serve.
REQ-035 p1_score=6, P1 scores -> p1_score=7, winner=1, GAME_OVER after 60 frames; serve=1 -> scores 0, SERVE.
REQ-036 Reset asserted mid-PLAY at ball (400,50) -> immediate SERVE, ball (316,236), scores 0 without waiting for a clock edge.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared encodings and default geometry for the pong controller.
// The optional PONG_AI_EN build reuses these constants unchanged.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_SERVE     = 2'd0,
    ST_PLAY      = 2'd1,
    ST_POINT     = 2'd2,
    ST_GAME_OVER = 2'd3
  } game_state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_P1   = 2'd1,
    WIN_P2   = 2'd2
  } winner_e;

  localparam int COORD_W          = 10;
  localparam int SCORE_W          = 4;
  localparam int DEF_SCREEN_W     = 640;
  localparam int DEF_SCREEN_H     = 480;
  localparam int DEF_PADDLE_W     = 20;
  localparam int DEF_PADDLE_H     = 80;
  localparam int DEF_BALL_SIZE    = 8;
  localparam int DEF_BALL_SPEED   = 2;
  localparam int DEF_PADDLE_SPEED = 4;
  localparam int DEF_WIN_SCORE    = 7;
  localparam int DEF_POINT_FRAMES = 60;

  function automatic logic [SCORE_W-1:0] sat_inc(
    input logic [SCORE_W-1:0] v,
    input logic [SCORE_W-1:0] lim
  );
    return (v >= lim) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/paddle_mover.sv
// One paddle: steps per frame tick, clamped to the screen,
// holds when both or neither direction is requested.
module paddle_mover
  import pong_pkg::*;
#(
  parameter int SCREEN_H     = DEF_SCREEN_H,
  parameter int PADDLE_H     = DEF_PADDLE_H,
  parameter int PADDLE_SPEED = DEF_PADDLE_SPEED
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               en,
  input  logic               up,
  input  logic               down,
  output logic [COORD_W-1:0] y
);

  localparam logic [COORD_W-1:0] Y_MAX =
    COORD_W'(SCREEN_H - PADDLE_H);
  localparam logic [COORD_W-1:0] Y_MID =
    COORD_W'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [COORD_W-1:0] STEP =
    COORD_W'(PADDLE_SPEED);
  localparam logic [COORD_W-1:0] Y_NEAR =
    COORD_W'(SCREEN_H - PADDLE_H - PADDLE_SPEED);

  logic [COORD_W-1:0] y_d;

  always_comb begin
    y_d = y;
    if (tick && en) begin
      unique case (1'b1)
        up && !down:
          y_d = (y <= STEP) ? '0 : y - STEP;
        down && !up:
          y_d = (y >= Y_NEAR) ? Y_MAX : y + STEP;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) y <= Y_MID;
    else     y <= y_d;
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game controller: ball, paddles, scoring and game flow.
// Define PONG_AI_EN to let player 2's paddle chase the ball.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int SCREEN_W     = DEF_SCREEN_W,
  parameter int SCREEN_H     = DEF_SCREEN_H,
  parameter int PADDLE_W     = DEF_PADDLE_W,
  parameter int PADDLE_H     = DEF_PADDLE_H,
  parameter int BALL_SIZE    = DEF_BALL_SIZE,
  parameter int BALL_SPEED   = DEF_BALL_SPEED,
  parameter int PADDLE_SPEED = DEF_PADDLE_SPEED,
  parameter int WIN_SCORE    = DEF_WIN_SCORE,
  parameter int POINT_FRAMES = DEF_POINT_FRAMES
) (
  input  logic               pixel_clk,
  input  logic               reset,
  input  logic               V_visible,
  input  logic               serve,
  input  logic               p1_up,
  input  logic               p1_down,
  input  logic               p2_up,
  input  logic               p2_down,
  output logic [COORD_W-1:0] p1_paddle_Y,
  output logic [COORD_W-1:0] p2_paddle_Y,
  output logic [COORD_W-1:0] ball_X,
  output logic [COORD_W-1:0] ball_Y,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [1:0]         game_state,
  output logic [1:0]         winner
);

  localparam int XW = COORD_W + 1;
  localparam int CW = $clog2(POINT_FRAMES + 1);

  localparam logic [COORD_W-1:0] X_MID =
    COORD_W'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [COORD_W-1:0] Y_MID =
    COORD_W'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [COORD_W-1:0] Y_BOT =
    COORD_W'(SCREEN_H - BALL_SIZE);
  localparam logic [COORD_W-1:0] Y_LOW =
    COORD_W'(SCREEN_H - BALL_SIZE - BALL_SPEED);
  localparam logic [COORD_W-1:0] X_LPAD =
    COORD_W'(PADDLE_W);
  localparam logic [COORD_W-1:0] X_RPAD =
    COORD_W'(SCREEN_W - PADDLE_W - BALL_SIZE);
  localparam logic [COORD_W-1:0] L_HIT =
    COORD_W'(PADDLE_W + BALL_SPEED);
  localparam logic [COORD_W-1:0] R_HIT =
    COORD_W'(SCREEN_W - PADDLE_W - BALL_SIZE - BALL_SPEED);
  localparam logic [COORD_W-1:0] R_MISS =
    COORD_W'(SCREEN_W - BALL_SIZE - BALL_SPEED);
  localparam logic [COORD_W-1:0] STEP =
    COORD_W'(BALL_SPEED);
  localparam logic [SCORE_W-1:0] WIN =
    SCORE_W'(WIN_SCORE);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(POINT_FRAMES - 1);

  logic               vis_q;
  logic               frame_tick;
  game_state_e        state_q, state_d;
  winner_e            win_q, win_d;
  logic [COORD_W-1:0] bx_q, bx_d;
  logic [COORD_W-1:0] by_q, by_d;
  logic               dx_q, dx_d;
  logic               dy_q, dy_d;
  logic [SCORE_W-1:0] s1_q, s1_d;
  logic [SCORE_W-1:0] s2_q, s2_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               tgt_q, tgt_d;
  logic               scored;
  logic [COORD_W-1:0] p1_y, p2_y;
  logic               paddle_en;
  logic               p2_cmd_up, p2_cmd_down;
  logic               hit_l, hit_r;
  logic [XW-1:0]      by_w;

  assign frame_tick = vis_q & ~V_visible;
  assign paddle_en  = (state_q != ST_GAME_OVER);

  // Overlap counts any shared pixel row between ball and paddle.
  assign by_w  = {1'b0, by_q};
  assign hit_l = (by_w + XW'(BALL_SIZE) > {1'b0, p1_y}) &&
                 (by_w < {1'b0, p1_y} + XW'(PADDLE_H));
  assign hit_r = (by_w + XW'(BALL_SIZE) > {1'b0, p2_y}) &&
                 (by_w < {1'b0, p2_y} + XW'(PADDLE_H));

`ifdef PONG_AI_EN
  logic [XW-1:0] ball_mid, p2_mid;
  assign ball_mid    = by_w + XW'(BALL_SIZE / 2);
  assign p2_mid      = {1'b0, p2_y} + XW'(PADDLE_H / 2);
  assign p2_cmd_down = (p2_mid + XW'(PADDLE_SPEED) < ball_mid);
  assign p2_cmd_up   = (ball_mid + XW'(PADDLE_SPEED) < p2_mid);
`else
  assign p2_cmd_up   = p2_up;
  assign p2_cmd_down = p2_down;
`endif

  paddle_mover #(
    .SCREEN_H    (SCREEN_H),
    .PADDLE_H    (PADDLE_H),
    .PADDLE_SPEED(PADDLE_SPEED)
  ) u_p1 (
    .clk (pixel_clk),
    .rst (reset),
    .tick(frame_tick),
    .en  (paddle_en),
    .up  (p1_up),
    .down(p1_down),
    .y   (p1_y)
  );

  paddle_mover #(
    .SCREEN_H    (SCREEN_H),
    .PADDLE_H    (PADDLE_H),
    .PADDLE_SPEED(PADDLE_SPEED)
  ) u_p2 (
    .clk (pixel_clk),
    .rst (reset),
    .tick(frame_tick),
    .en  (paddle_en),
    .up  (p2_cmd_up),
    .down(p2_cmd_down),
    .y   (p2_y)
  );

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    bx_d    = bx_q;
    by_d    = by_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    scored  = 1'b0;
    if (frame_tick) begin
      unique case (state_q)
        ST_SERVE: begin
          bx_d = X_MID;
          by_d = Y_MID;
          if (serve) begin
            state_d = ST_PLAY;
            dx_d    = tgt_q;
            dy_d    = 1'b1;
          end
        end
        ST_PLAY: begin
          if (dy_q) begin
            if (by_q >= Y_LOW) begin
              by_d = Y_BOT;
              dy_d = 1'b0;
            end else begin
              by_d = by_q + STEP;
            end
          end else if (by_q <= STEP) begin
            by_d = '0;
            dy_d = 1'b1;
          end else begin
            by_d = by_q - STEP;
          end
          // Paddle contact wins over a miss on the same tick.
          if (!dx_q) begin
            if (bx_q <= L_HIT && hit_l) begin
              bx_d = X_LPAD;
              dx_d = 1'b1;
            end else if (bx_q < STEP) begin
              s2_d   = sat_inc(s2_q, WIN);
              tgt_d  = 1'b0;
              scored = 1'b1;
            end else begin
              bx_d = bx_q - STEP;
            end
          end else begin
            if (bx_q >= R_HIT && hit_r) begin
              bx_d = X_RPAD;
              dx_d = 1'b0;
            end else if (bx_q > R_MISS) begin
              s1_d   = sat_inc(s1_q, WIN);
              tgt_d  = 1'b1;
              scored = 1'b1;
            end else begin
              bx_d = bx_q + STEP;
            end
          end
          if (scored) begin
            state_d = ST_POINT;
            cnt_d   = '0;
            bx_d    = X_MID;
            by_d    = Y_MID;
          end
        end
        ST_POINT: begin
          bx_d = X_MID;
          by_d = Y_MID;
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (s1_q == WIN) begin
              state_d = ST_GAME_OVER;
              win_d   = WIN_P1;
            end else if (s2_q == WIN) begin
              state_d = ST_GAME_OVER;
              win_d   = WIN_P2;
            end else begin
              state_d = ST_SERVE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_GAME_OVER: begin
          if (serve) begin
            state_d = ST_SERVE;
            win_d   = WIN_NONE;
            s1_d    = '0;
            s2_d    = '0;
            tgt_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      vis_q   <= 1'b0;
      state_q <= ST_SERVE;
      win_q   <= WIN_NONE;
      bx_q    <= X_MID;
      by_q    <= Y_MID;
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      s1_q    <= '0;
      s2_q    <= '0;
      cnt_q   <= '0;
      tgt_q   <= 1'b1;
    end else begin
      vis_q   <= V_visible;
      state_q <= state_d;
      win_q   <= win_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
    end
  end

  assign p1_paddle_Y = p1_y;
  assign p2_paddle_Y = p2_y;
  assign ball_X      = bx_q;
  assign ball_Y      = by_q;
  assign p1_score    = s1_q;
  assign p2_score    = s2_q;
  assign game_state  = state_q;
  assign winner      = win_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: frame-level game model plus
// directed literal checks and randomized play.
module tb_pong_game_ctrl;

  localparam int W = 640, H = 480, PW = 20, PH = 80, B = 8;
  localparam int BS = 2, PS = 4, WS = 7, PF = 60;
  localparam int PMAX = H - PH;
  localparam int CX = (W - B) / 2, CY = (H - B) / 2;

  logic       pixel_clk = 1'b0;
  logic       reset = 1'b1;
  logic       V_visible = 1'b0, serve = 1'b0;
  logic       p1_up = 1'b0, p1_down = 1'b0;
  logic       p2_up = 1'b0, p2_down = 1'b0;
  logic [9:0] p1_paddle_Y, p2_paddle_Y, ball_X, ball_Y;
  logic [3:0] p1_score, p2_score;
  logic [1:0] game_state, winner;

  int n_cmp = 0, n_bad = 0;
  bit chk_en = 0;

  // Model state: st 0..3, dx/dy as +1/-1, tgt 1 = serve rightward.
  int m_st, m_bx, m_by, m_dx, m_dy, m_p1, m_p2;
  int m_s1, m_s2, m_win, m_cnt, m_tgt;
  bit m_prev;

  pong_game_ctrl #(
    .SCREEN_W(W), .SCREEN_H(H), .PADDLE_W(PW), .PADDLE_H(PH),
    .BALL_SIZE(B), .BALL_SPEED(BS), .PADDLE_SPEED(PS),
    .WIN_SCORE(WS), .POINT_FRAMES(PF)
  ) dut (
    .pixel_clk(pixel_clk), .reset(reset), .V_visible(V_visible),
    .serve(serve), .p1_up(p1_up), .p1_down(p1_down),
    .p2_up(p2_up), .p2_down(p2_down),
    .p1_paddle_Y(p1_paddle_Y), .p2_paddle_Y(p2_paddle_Y),
    .ball_X(ball_X), .ball_Y(ball_Y),
    .p1_score(p1_score), .p2_score(p2_score),
    .game_state(game_state), .winner(winner)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pmove(input int y, input bit up, input bit dn);
    if (up && !dn) return (y <= PS) ? 0 : y - PS;
    if (dn && !up) return (y >= PMAX - PS) ? PMAX : y + PS;
    return y;
  endfunction

  task automatic m_reset();
    m_st = 0; m_bx = CX; m_by = CY; m_dx = 1; m_dy = 1;
    m_p1 = PMAX / 2; m_p2 = PMAX / 2;
    m_s1 = 0; m_s2 = 0; m_win = 0; m_cnt = 0; m_tgt = 1;
  endtask

  task automatic m_tick();
    int n1, n2, nx, ny;
    bit a_up, a_dn, go;
    go = (m_st != 3);
    a_up = p2_up;
    a_dn = p2_down;
`ifdef PONG_AI_EN
    a_dn = (m_p2 + PH / 2 + PS < m_by + B / 2);
    a_up = (m_by + B / 2 + PS < m_p2 + PH / 2);
`endif
    n1 = go ? pmove(m_p1, p1_up, p1_down) : m_p1;
    n2 = go ? pmove(m_p2, a_up, a_dn) : m_p2;
    case (m_st)
      0: if (serve) begin
        m_st = 1; m_dx = m_tgt ? 1 : -1; m_dy = 1;
      end
      1: begin
        if (m_dy < 0) begin
          if (m_by <= BS) begin ny = 0; m_dy = 1; end
          else ny = m_by - BS;
        end else begin
          if (m_by >= H - B - BS) begin ny = H - B; m_dy = -1; end
          else ny = m_by + BS;
        end
        nx = m_bx;
        if (m_dx < 0) begin
          if (m_bx <= PW + BS && m_by + B > m_p1 && m_by < m_p1 + PH) begin
            nx = PW; m_dx = 1;
          end else if (m_bx < BS) begin
            m_s2 = (m_s2 < WS) ? m_s2 + 1 : WS; m_tgt = 0; m_st = 2;
          end else nx = m_bx - BS;
        end else begin
          if (m_bx >= W - PW - B - BS && m_by + B > m_p2 && m_by < m_p2 + PH) begin
            nx = W - PW - B; m_dx = -1;
          end else if (W - B - m_bx < BS) begin
            m_s1 = (m_s1 < WS) ? m_s1 + 1 : WS; m_tgt = 1; m_st = 2;
          end else nx = m_bx + BS;
        end
        if (m_st == 2) begin m_bx = CX; m_by = CY; m_cnt = 0; end
        else begin m_bx = nx; m_by = ny; end
      end
      2: begin
        if (m_cnt == PF - 1) begin
          m_cnt = 0;
          if (m_s1 == WS) begin m_st = 3; m_win = 1; end
          else if (m_s2 == WS) begin m_st = 3; m_win = 2; end
          else m_st = 0;
        end else m_cnt++;
      end
      default: if (serve) begin
        m_st = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_tgt = 1;
      end
    endcase
    m_p1 = n1;
    m_p2 = n2;
  endtask

  initial begin : model
    m_reset();
    m_prev = 0;
    forever begin
      @(posedge pixel_clk or posedge reset);
      if (reset) begin
        m_reset();
        m_prev = 0;
      end else begin
        if (m_prev && !V_visible) m_tick();
        m_prev = V_visible;
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge pixel_clk);
      if (chk_en && !reset) begin
        check("state", int'(game_state), m_st);
        check("ball_X", int'(ball_X), m_bx);
        check("ball_Y", int'(ball_Y), m_by);
        check("p1_Y", int'(p1_paddle_Y), m_p1);
        check("p2_Y", int'(p2_paddle_Y), m_p2);
        check("p1_score", int'(p1_score), m_s1);
        check("p2_score", int'(p2_score), m_s2);
        check("winner", int'(winner), m_win);
      end
    end
  end

  task automatic frame(input int h, input int l);
    V_visible = 1'b1;
    repeat (h) begin @(posedge pixel_clk); #1; end
    V_visible = 1'b0;
    repeat (l) begin @(posedge pixel_clk); #1; end
  endtask

  task automatic frames(input int n);
    repeat (n) frame(2, 1);
  endtask

  task automatic do_reset();
    {serve, p1_up, p1_down, p2_up, p2_down} = '0;
    V_visible = 1'b0;
    reset = 1'b1;
    repeat (2) begin @(posedge pixel_clk); #1; end
    reset = 1'b0;
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  initial begin : watchdog
    #900000;
    n_bad++;
    $display("FAIL watchdog: bench did not finish in time");
    summary();
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int f;
    do_reset();
    chk_en = 1;
    check("rst_state", int'(game_state), 0);
    check("rst_ball_X", int'(ball_X), 316);
    check("rst_ball_Y", int'(ball_Y), 236);
    check("rst_p1_Y", int'(p1_paddle_Y), 200);
    check("rst_p2_Y", int'(p2_paddle_Y), 200);
    check("rst_scores", int'({p1_score, p2_score}), 0);
    check("rst_winner", int'(winner), 0);

    frames(3);
    check("idle_state", int'(game_state), 0);
    serve = 1'b1;
    frames(1);
    serve = 1'b0;
    check("serve_state", int'(game_state), 1);
    check("serve_ball_X", int'(ball_X), 316);
    frames(1);
    check("first_move_X", int'(ball_X), 318);
    check("first_move_Y", int'(ball_Y), 238);
    frames(157);
    check("edge_X", int'(ball_X), 632);
    check("edge_state", int'(game_state), 1);
    frames(1);
    check("point_state", int'(game_state), 2);
    check("point_p1", int'(p1_score), 1);
    check("point_ball_X", int'(ball_X), 316);
    frames(59);
    check("point_hold", int'(game_state), 2);
    frames(1);
    check("point_done", int'(game_state), 0);

    do_reset();
    p1_up = 1'b1;
    frames(49);
    check("p1_49", int'(p1_paddle_Y), 4);
    frames(1);
    check("p1_50", int'(p1_paddle_Y), 0);
    frames(10);
    check("p1_clamp", int'(p1_paddle_Y), 0);
    p1_up = 1'b0;
    p1_down = 1'b1;
    frames(5);
    check("p1_down5", int'(p1_paddle_Y), 20);
    p1_up = 1'b1;
    frames(5);
    check("p1_both", int'(p1_paddle_Y), 20);
    {p1_up, p1_down} = '0;
`ifndef PONG_AI_EN
    p2_down = 1'b1;
    frames(60);
    check("p2_clamp", int'(p2_paddle_Y), 400);
    p2_down = 1'b0;
`endif

    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        p1_up = 1'($urandom_range(0, 1));
        p1_down = 1'($urandom_range(0, 1));
        p2_up = 1'($urandom_range(0, 1));
        p2_down = 1'($urandom_range(0, 1));
      end
      serve = ($urandom_range(0, 3) == 0);
      frame($urandom_range(1, 4), $urandom_range(1, 3));
    end

    serve = 1'b1;
    f = 0;
    while (m_st != 1 && f < 2000) begin frames(1); f++; end
    serve = 1'b0;
    check("reach_play", m_st, 1);
    frames(20);
    #2 reset = 1'b1;
    #1;
    check("arst_state", int'(game_state), 0);
    check("arst_ball_X", int'(ball_X), 316);
    check("arst_ball_Y", int'(ball_Y), 236);
    check("arst_scores", int'({p1_score, p2_score}), 0);
    check("arst_p1_Y", int'(p1_paddle_Y), 200);
    repeat (2) begin @(posedge pixel_clk); #1; end
    reset = 1'b0;

    do_reset();
    p2_up = 1'b1;
    f = 0;
    while (m_st != 3 && f < 4000) begin
      p1_up = (m_p1 + PH / 2 > m_by + B / 2 + 2);
      p1_down = (m_p1 + PH / 2 + 2 < m_by + B / 2);
      serve = (m_st == 0);
      frames(1);
      f++;
    end
    {serve, p1_up, p1_down} = '0;
    check("win_reached", m_st, 3);
    check("go_state", int'(game_state), 3);
    check("go_winner", int'(winner), 1);
    check("go_p1", int'(p1_score), 7);
    check("go_p2", int'(p2_score), 0);
    frames(3);
    check("go_frozen", int'(game_state), 3);
    serve = 1'b1;
    frames(1);
    serve = 1'b0;
    check("restart_state", int'(game_state), 0);
    check("restart_scores", int'({p1_score, p2_score}), 0);
    check("restart_winner", int'(winner), 0);
    frames(2);

    summary();
    $finish;
  end

endmodule
